// File: rtl/eth_switch_pkg.sv
// Shared widths, control characters and types for the switch receive path.
// Also holds the byte-order helper used by the header parser.
package eth_switch_pkg;

  localparam int NUM_OF_PORTS       = 4;
  localparam int RXTX_DATA_SIZE     = 32;
  localparam int RXTXCTRL_BITS_SIZE = 4;
  localparam int DST_MAC_LEN        = 64;
  localparam int SRC_MAC_LEN        = 64;
  localparam int MAC_ADDR_BITS      = 48;

  localparam logic [7:0]  START_CH     = 8'hFB;
  localparam logic [7:0]  TERM_CH      = 8'hFD;
  localparam logic [7:0]  ERR_CH       = 8'hFE;
  localparam logic [31:0] PRE_SFD_WORD = 32'hD5555555;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRE     = 3'd1,
    ST_DA0     = 3'd2,
    ST_DA1SA0  = 3'd3,
    ST_SA1     = 3'd4,
    ST_PAYLOAD = 3'd5
  } rx_state_e;

  // Lane 0 arrives first on the wire but is the most significant address byte.
  function automatic logic [31:0] lane_to_addr32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/eth_rx_hdr_parser.sv
// Per-port receive parser: finds start/preamble, extracts the MAC address pair,
// tracks frame termination and hands headers over with a valid/ready handshake.
module eth_rx_hdr_parser
  import eth_switch_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [RXTX_DATA_SIZE-1:0]     rxd,
  input  logic [RXTXCTRL_BITS_SIZE-1:0] rxc,
  output logic [DST_MAC_LEN-1:0]        dst_mac,
  output logic [SRC_MAC_LEN-1:0]        src_mac,
  output logic                          hdr_valid,
  input  logic                          hdr_ready,
  output logic                          frame_active,
  output logic                          frame_end,
  output logic                          frame_err,
  output logic [7:0]                    drop_cnt
);

  rx_state_e                r_state;
  rx_state_e                w_state_nxt;
  logic                     w_start;
  logic                     w_lane_term;
  logic                     w_lane_err;
  logic                     w_err;
  logic                     w_end;
  logic                     w_hdr_done;
  logic                     w_load;
  logic [MAC_ADDR_BITS-1:0] r_da_sh;
  logic [15:0]              r_sa_hi_sh;
  logic [DST_MAC_LEN-1:0]   w_dst_new;
  logic [SRC_MAC_LEN-1:0]   w_src_new;
  logic [DST_MAC_LEN-1:0]   r_dst_mac;
  logic [SRC_MAC_LEN-1:0]   r_src_mac;
  logic                     r_hdr_valid;
  logic                     r_frame_active;
  logic                     r_frame_end;
  logic                     r_frame_err;
  logic [7:0]               r_drop_cnt;

  assign w_start = (rxc == 4'b0001) && (rxd[7:0] == START_CH);

  // Scan lanes for terminate / error control characters.
  always_comb begin
    w_lane_term = 1'b0;
    w_lane_err  = 1'b0;
    for (int n = 0; n < RXTXCTRL_BITS_SIZE; n++) begin
      if (rxc[n] && (rxd[8*n +: 8] == TERM_CH)) begin
        w_lane_term = 1'b1;
      end else if (rxc[n] && (rxd[8*n +: 8] == ERR_CH)) begin
        w_lane_err = 1'b1;
      end else begin
        w_lane_term = w_lane_term;
      end
    end
  end

  // Next-state and pulse decode; a start word overrides everything else.
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_end       = 1'b0;
    w_hdr_done  = 1'b0;
    if (w_start) begin
      w_state_nxt = ST_PRE;
      w_err       = (r_state != ST_IDLE);
    end else begin
      case (r_state)
        ST_IDLE: w_state_nxt = ST_IDLE;
        ST_PRE: begin
          if ((rxc == 4'b0000) && (rxd == PRE_SFD_WORD)) begin
            w_state_nxt = ST_DA0;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_DA0, ST_DA1SA0, ST_SA1: begin
          if (|rxc) begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (r_state == ST_DA0) begin
            w_state_nxt = ST_DA1SA0;
          end else if (r_state == ST_DA1SA0) begin
            w_state_nxt = ST_SA1;
          end else begin
            w_hdr_done  = 1'b1;
            w_state_nxt = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (w_lane_err) begin
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (w_lane_term) begin
            w_end       = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_PAYLOAD;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Assemble the completed header from the shadow plus the final source word.
  always_comb begin
    w_dst_new = '0;
    w_src_new = '0;
    w_dst_new[MAC_ADDR_BITS-1:0] = r_da_sh;
    w_src_new[MAC_ADDR_BITS-1:0] = {r_sa_hi_sh, lane_to_addr32(rxd)};
  end

  // Completed header is taken unless the previous one is still unaccepted.
  assign w_load = w_hdr_done && (!r_hdr_valid || hdr_ready);

  // State register and header shadow capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_da_sh        <= '0;
      r_sa_hi_sh     <= '0;
      r_frame_active <= 1'b0;
      r_frame_end    <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_frame_active <= (w_state_nxt != ST_IDLE);
      r_frame_end    <= w_end && !w_err;
      r_frame_err    <= w_err;
      if (!w_start && (rxc == 4'b0000) && (r_state == ST_DA0)) begin
        r_da_sh[47:16] <= lane_to_addr32(rxd);
      end else if (!w_start && (rxc == 4'b0000) && (r_state == ST_DA1SA0)) begin
        r_da_sh[15:0] <= {rxd[7:0], rxd[15:8]};
        r_sa_hi_sh    <= {rxd[23:16], rxd[31:24]};
      end else begin
        r_da_sh <= r_da_sh;
      end
    end
  end

  // Output header handshake and drop accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dst_mac   <= '0;
      r_src_mac   <= '0;
      r_hdr_valid <= 1'b0;
      r_drop_cnt  <= 8'd0;
    end else if (w_load) begin
      r_dst_mac   <= w_dst_new;
      r_src_mac   <= w_src_new;
      r_hdr_valid <= 1'b1;
    end else if (w_hdr_done) begin
      if (r_drop_cnt != 8'hFF) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (r_hdr_valid && hdr_ready) begin
      r_hdr_valid <= 1'b0;
    end
  end

  assign dst_mac      = r_dst_mac;
  assign src_mac      = r_src_mac;
  assign hdr_valid    = r_hdr_valid;
  assign frame_active = r_frame_active;
  assign frame_end    = r_frame_end;
  assign frame_err    = r_frame_err;
  assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_eth_rx_hdr_parser.sv
// Directed bench for eth_rx_hdr_parser: good frames, framing errors,
// backpressure drops, same-cycle handover and mid-frame reset.
module tb_eth_rx_hdr_parser;
  import eth_switch_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] rxd;
  logic [3:0]  rxc;
  logic [63:0] dst_mac;
  logic [63:0] src_mac;
  logic        hdr_valid;
  logic        hdr_ready;
  logic        frame_active;
  logic        frame_end;
  logic        frame_err;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  eth_rx_hdr_parser dut (
    .clk(clk), .rst(rst), .rxd(rxd), .rxc(rxc),
    .dst_mac(dst_mac), .src_mac(src_mac),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .frame_active(frame_active), .frame_end(frame_end),
    .frame_err(frame_err), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one word for one clock, return #1 after the edge.
  task automatic send(input logic [3:0] c, input logic [31:0] d);
    rxc = c;
    rxd = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [47:0] da, input logic [47:0] sa);
    send(4'b0001, 32'h555555FB);
    send(4'b0000, 32'hD5555555);
    send(4'b0000, {da[23:16], da[31:24], da[39:32], da[47:40]});
    send(4'b0000, {sa[39:32], sa[47:40], da[7:0], da[15:8]});
    send(4'b0000, {sa[7:0], sa[15:8], sa[23:16], sa[31:24]});
  endtask

  localparam logic [31:0] TERM_L2 = 32'h07FD1234;

  initial begin
    rst = 1'b1; rxd = 32'h0; rxc = 4'h0; hdr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dst", dst_mac, 64'h0);
    check("rst_valid", {63'd0, hdr_valid}, 64'd0);
    check("rst_drop", {56'd0, drop_cnt}, 64'd0);
    rst = 1'b0;
    send(4'h0, 32'h07070707);
    check("idle_active", {63'd0, frame_active}, 64'd0);

    // Good frame with literal words in wire order.
    send(4'b0001, 32'h555555FB);
    check("start_active", {63'd0, frame_active}, 64'd1);
    send(4'b0000, 32'hD5555555);
    send(4'b0000, 32'h33221100);
    send(4'b0000, 32'hBBAA5544);
    send(4'b0000, 32'hFFEEDDCC);
    check("good_valid", {63'd0, hdr_valid}, 64'd1);
    check("good_dst", dst_mac, 64'h0000001122334455);
    check("good_src", src_mac, 64'h0000AABBCCDDEEFF);
    send(4'b0000, 32'h01020304);
    check("good_valid_drop", {63'd0, hdr_valid}, 64'd0);
    send(4'b1100, TERM_L2);
    check("good_end", {63'd0, frame_end}, 64'd1);
    check("good_err", {63'd0, frame_err}, 64'd0);
    check("good_inactive", {63'd0, frame_active}, 64'd0);
    send(4'hF, 32'h07070707);
    check("good_end_pulse", {63'd0, frame_end}, 64'd0);

    // Bad preamble.
    send(4'b0001, 32'h555555FB);
    send(4'b0000, 32'h55555555);
    check("badpre_err", {63'd0, frame_err}, 64'd1);
    check("badpre_active", {63'd0, frame_active}, 64'd0);
    check("badpre_valid", {63'd0, hdr_valid}, 64'd0);

    // Terminate inside DA1SA0.
    send(4'b0001, 32'h555555FB);
    send(4'b0000, 32'hD5555555);
    send(4'b0000, 32'h33221100);
    send(4'b0100, 32'h07FD5544);
    check("runt_err", {63'd0, frame_err}, 64'd1);
    check("runt_end", {63'd0, frame_end}, 64'd0);
    send(4'hF, 32'h07070707);
    check("runt_valid", {63'd0, hdr_valid}, 64'd0);

    // Backpressure: second header dropped, first held.
    hdr_ready = 1'b0;
    send_hdr(48'h0A0B0C0D0E0F, 48'h102030405060);
    send(4'b1100, TERM_L2);
    send_hdr(48'h111111111111, 48'h222222222222);
    check("bp_valid", {63'd0, hdr_valid}, 64'd1);
    check("bp_dst", dst_mac, 64'h00000A0B0C0D0E0F);
    check("bp_src", src_mac, 64'h0000102030405060);
    check("bp_drop1", {56'd0, drop_cnt}, 64'd1);
    send(4'b1100, TERM_L2);
    for (int i = 0; i < 300; i++) begin
      send_hdr(48'h333333333333, 48'h444444444444);
      send(4'b1100, TERM_L2);
    end
    check("bp_drop_sat", {56'd0, drop_cnt}, 64'd255);
    check("bp_dst_hold", dst_mac, 64'h00000A0B0C0D0E0F);

    // Header completes in the same cycle the held one is accepted.
    send(4'b0001, 32'h555555FB);
    send(4'b0000, 32'hD5555555);
    send(4'b0000, 32'h33221100);
    send(4'b0000, 32'hBBAA5544);
    hdr_ready = 1'b1;
    send(4'b0000, 32'hFFEEDDCC);
    hdr_ready = 1'b0;
    check("swap_valid", {63'd0, hdr_valid}, 64'd1);
    check("swap_dst", dst_mac, 64'h0000001122334455);
    check("swap_drop", {56'd0, drop_cnt}, 64'd255);

    // FE in payload keeps the presented header.
    send(4'b0000, 32'hCAFEF00D);
    send(4'b0001, 32'h000000FE);
    check("fe_err", {63'd0, frame_err}, 64'd1);
    check("fe_end", {63'd0, frame_end}, 64'd0);
    check("fe_valid", {63'd0, hdr_valid}, 64'd1);
    check("fe_src", src_mac, 64'h0000AABBCCDDEEFF);

    // Start word inside payload restarts with an error pulse.
    send_hdr(48'h555555555555, 48'h666666666666);
    send(4'b0001, 32'h555555FB);
    check("restart_err", {63'd0, frame_err}, 64'd1);
    check("restart_active", {63'd0, frame_active}, 64'd1);
    send(4'hF, 32'h07070707);

    // Reset while in DA0, then a good frame.
    send(4'b0001, 32'h555555FB);
    send(4'b0000, 32'hD5555555);
    rxc = 4'b0000; rxd = 32'h33221100;
    #2 rst = 1'b1;
    #1;
    check("mrst_valid", {63'd0, hdr_valid}, 64'd0);
    check("mrst_dst", dst_mac, 64'h0);
    check("mrst_src", src_mac, 64'h0);
    check("mrst_drop", {56'd0, drop_cnt}, 64'd0);
    check("mrst_active", {63'd0, frame_active}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    hdr_ready = 1'b1;
    send(4'b0000, 32'h33221100);
    check("mrst_idle", {63'd0, frame_active}, 64'd0);
    send_hdr(48'h001122334455, 48'hAABBCCDDEEFF);
    check("mrst_hdr_valid", {63'd0, hdr_valid}, 64'd1);
    check("mrst_hdr_dst", dst_mac, 64'h0000001122334455);
    check("mrst_hdr_src", src_mac, 64'h0000AABBCCDDEEFF);
    send(4'b1100, TERM_L2);
    check("mrst_end", {63'd0, frame_end}, 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
